// File: rtl/wdt_rst_ctrl.sv
// Watchdog timer controller: down-counter with kick/reload, optional interrupt-first
// response, and a registered system reset pulse of 2^(rpl+1) pclk cycles.
module wdt_rst_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          HC_RPL   = 1'b0,
  parameter logic [2:0]  DFLT_RPL = 3'd3
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             wdt_en,
  input  logic             resp_mode,
  input  logic [CNT_W-1:0] top_val,
  input  logic             kick,
  input  logic             intr_clr,
  input  logic             rpl_wr,
  input  logic [2:0]       rpl_in,
  output logic [2:0]       rpl,
  output logic [CNT_W-1:0] cnt,
  output logic             wdt_intr,
  output logic             wdt_rst
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCount = 2'd1;
  localparam logic [1:0] StIntr  = 2'd2;
  localparam logic [1:0] StRst   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             intr_q, intr_d;
  logic             rst_q, rst_d;
  logic [2:0]       rpl_q, rpl_d;
  logic [8:0]       pcnt_q, pcnt_d;

  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;
  logic [8:0]       pulse_last;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  // rpl cannot change while in StRst, so this is effectively latched at pulse start.
  assign pulse_last = (9'd2 << rpl_q) - 9'd1;

  always_comb begin
    rpl_d = rpl_q;
    if (!HC_RPL && rpl_wr && (state_q != StRst)) begin
      rpl_d = rpl_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    intr_d  = intr_q;
    rst_d   = rst_q;
    pcnt_d  = pcnt_q;

    case (state_q)
      StIdle: begin
        intr_d = 1'b0;
        rst_d  = 1'b0;
        if (wdt_en) begin
          cnt_d   = top_val;
          state_d = StCount;
        end
      end

      StCount: begin
        if (!wdt_en) begin
          state_d = StIdle;
        end else if (kick) begin
          cnt_d = top_val;
        end else if (cnt_zero && !resp_mode) begin
          state_d = StRst;
          rst_d   = 1'b1;
          pcnt_d  = '0;
        end else if (cnt_zero) begin
          intr_d  = 1'b1;
          cnt_d   = top_val;
          state_d = StIntr;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      StIntr: begin
        if (!wdt_en) begin
          intr_d  = 1'b0;
          state_d = StIdle;
        end else if (kick) begin
          cnt_d   = top_val;
          intr_d  = 1'b0;
          state_d = StCount;
        end else if (intr_clr) begin
          // Keep counting down without reloading; saturate so a clear at zero cannot wrap.
          intr_d  = 1'b0;
          state_d = StCount;
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end
        end else if (cnt_zero) begin
          state_d = StRst;
          rst_d   = 1'b1;
          pcnt_d  = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      StRst: begin
        if (pcnt_q == pulse_last) begin
          rst_d   = 1'b0;
          intr_d  = 1'b0;
          cnt_d   = top_val;
          pcnt_d  = '0;
          state_d = wdt_en ? StCount : StIdle;
        end else begin
          pcnt_d = pcnt_q + 9'd1;
        end
      end

      default: begin
        state_d = StIdle;
        intr_d  = 1'b0;
        rst_d   = 1'b0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
      rst_q   <= 1'b0;
      rpl_q   <= DFLT_RPL;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
      rst_q   <= rst_d;
      rpl_q   <= rpl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign rpl      = rpl_q;
  assign cnt      = cnt_q;
  assign wdt_intr = intr_q;
  assign wdt_rst  = rst_q;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Scoreboard bench for wdt_rst_ctrl: two instances (rpl writable / hard-coded) driven by
// directed and random stimulus, checked every cycle against a behavioural model.
module tb_wdt_rst_ctrl;

  localparam int unsigned CW = 16;
  localparam int DFLT = 3;

  logic          pclk = 1'b0;
  logic          presetn, wdt_en, resp_mode, kick, intr_clr, rpl_wr;
  logic [CW-1:0] top_val;
  logic [2:0]    rpl_in;
  logic [2:0]    rpl0, rpl1;
  logic [CW-1:0] cnt0, cnt1;
  logic          intr0, intr1, rst0, rst1;

  always #5 pclk = ~pclk;

  wdt_rst_ctrl #(.CNT_W(CW), .HC_RPL(1'b0), .DFLT_RPL(3'd3)) dut0 (
    .pclk(pclk), .presetn(presetn), .wdt_en(wdt_en), .resp_mode(resp_mode),
    .top_val(top_val), .kick(kick), .intr_clr(intr_clr), .rpl_wr(rpl_wr), .rpl_in(rpl_in),
    .rpl(rpl0), .cnt(cnt0), .wdt_intr(intr0), .wdt_rst(rst0)
  );

  wdt_rst_ctrl #(.CNT_W(CW), .HC_RPL(1'b1), .DFLT_RPL(3'd3)) dut1 (
    .pclk(pclk), .presetn(presetn), .wdt_en(wdt_en), .resp_mode(resp_mode),
    .top_val(top_val), .kick(kick), .intr_clr(intr_clr), .rpl_wr(rpl_wr), .rpl_in(rpl_in),
    .rpl(rpl1), .cnt(cnt1), .wdt_intr(intr1), .wdt_rst(rst1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 counting, 2 interrupt pending, 3 reset pulse.
  int m_ph[2], m_cnt[2], m_left[2], m_len[2], m_rpl[2];
  bit m_intr[2], m_rst[2];

  logic [20:0] exp_q0[$], exp_q1[$];
  int          wq0[$], wq1[$];
  int          run[2];

  task automatic push_exp(input int i);
    logic [20:0] e;
    logic [CW-1:0] c;
    logic [2:0] r;
    c = CW'(m_cnt[i]);
    r = 3'(m_rpl[i]);
    e = {c, m_intr[i], m_rst[i], r};
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic push_w(input int i, input int w);
    if (i == 0) wq0.push_back(w);
    else wq1.push_back(w);
  endtask

  task automatic start_pulse(input int i, input int r);
    m_ph[i]   = 3;
    m_rst[i]  = 1'b1;
    m_len[i]  = 1 << (r + 1);
    m_left[i] = m_len[i] - 1;
  endtask

  task automatic model_step(input int i);
    int nrpl;
    if (!presetn) begin
      if (m_ph[i] == 3) push_w(i, m_len[i] - m_left[i]);
      m_ph[i] = 0; m_cnt[i] = 0; m_intr[i] = 0; m_rst[i] = 0; m_rpl[i] = DFLT;
    end else begin
      nrpl = m_rpl[i];
      if (i == 0 && rpl_wr && m_ph[i] != 3) nrpl = int'(rpl_in);
      case (m_ph[i])
        0: if (wdt_en) begin m_cnt[i] = int'(top_val); m_ph[i] = 1; end
        1: begin
          if (!wdt_en) m_ph[i] = 0;
          else if (kick) m_cnt[i] = int'(top_val);
          else if (m_cnt[i] == 0 && !resp_mode) start_pulse(i, nrpl);
          else if (m_cnt[i] == 0) begin
            m_intr[i] = 1; m_cnt[i] = int'(top_val); m_ph[i] = 2;
          end else m_cnt[i]--;
        end
        2: begin
          if (!wdt_en) begin m_ph[i] = 0; m_intr[i] = 0; end
          else if (kick) begin m_cnt[i] = int'(top_val); m_intr[i] = 0; m_ph[i] = 1; end
          else if (intr_clr) begin
            m_intr[i] = 0; m_ph[i] = 1;
            if (m_cnt[i] > 0) m_cnt[i]--;
          end else if (m_cnt[i] == 0) start_pulse(i, nrpl);
          else m_cnt[i]--;
        end
        default: begin
          if (m_left[i] == 0) begin
            push_w(i, m_len[i]);
            m_rst[i] = 0; m_intr[i] = 0; m_cnt[i] = int'(top_val);
            m_ph[i] = wdt_en ? 1 : 0;
          end else m_left[i]--;
        end
      endcase
      m_rpl[i] = nrpl;
    end
    push_exp(i);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge pclk);
    #2;
  endtask

  task automatic check_out(input int i, input logic [20:0] act);
    logic [20:0] e;
    if (i == 0) begin
      if (exp_q0.size() == 0) return;
      e = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return;
      e = exp_q1.pop_front();
    end
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL outputs dut%0d t=%0t got cnt=%0d intr=%b rst=%b rpl=%0d want cnt=%0d intr=%b rst=%b rpl=%0d",
               i, $time, act[20:5], act[4], act[3], act[2:0], e[20:5], e[4], e[3], e[2:0]);
    end
  endtask

  task automatic check_width(input int i, input logic r);
    int w;
    if (r === 1'b1) begin
      run[i]++;
    end else if (run[i] > 0) begin
      checks++;
      if ((i == 0 ? wq0.size() : wq1.size()) == 0) begin
        errors++;
        $display("FAIL pulse_width dut%0d got %0d cycles want no pulse", i, run[i]);
      end else begin
        w = (i == 0) ? wq0.pop_front() : wq1.pop_front();
        if (w != run[i]) begin
          errors++;
          $display("FAIL pulse_width dut%0d got %0d cycles want %0d", i, run[i], w);
        end
      end
      run[i] = 0;
    end
  endtask

  always @(posedge pclk) begin
    #1;
    check_out(0, {cnt0, intr0, rst0, rpl0});
    check_out(1, {cnt1, intr1, rst1, rpl1});
    check_width(0, rst0);
    check_width(1, rst1);
  end

  task automatic bound_fail(input string what);
    checks++;
    errors++;
    $display("FAIL bound %s expired at t=%0t", what, $time);
  endtask

  task automatic settle();
    int g;
    for (g = 0; g < 600 && (m_ph[0] == 3 || m_ph[1] == 3); g++) tick();
    if (g == 600) bound_fail("settle");
    tick();
  endtask

  initial begin
    int g;
    run[0] = 0; run[1] = 0;
    presetn = 0; wdt_en = 0; resp_mode = 0; kick = 0; intr_clr = 0; rpl_wr = 0;
    rpl_in = 0; top_val = 5;
    repeat (3) tick();
    presetn = 1;

    // Mode 0, top 5: pulse of 16 starting 7 cycles after enable, then periodic restart.
    wdt_en = 1;
    repeat (40) tick();

    // rpl sweep on both instances.
    for (int r = 0; r < 8; r++) begin
      wdt_en = 0;
      settle();
      rpl_wr = 1; rpl_in = 3'(r); tick(); rpl_wr = 0;
      top_val = 2; wdt_en = 1;
      repeat ((2 << r) + 8) tick();
    end

    // Interrupt-first mode with no action, then with intr_clr.
    wdt_en = 0; settle();
    resp_mode = 1; top_val = 4; wdt_en = 1;
    repeat (25) tick();
    wdt_en = 0; settle(); wdt_en = 1;
    for (g = 0; g < 50 && !m_intr[0]; g++) tick();
    if (g == 50) bound_fail("intr_rise");
    repeat (2) tick();
    intr_clr = 1; tick(); intr_clr = 0;
    repeat (12) tick();

    // Kick exactly at cnt==0, then kick every 3 cycles.
    wdt_en = 0; settle();
    resp_mode = 0; top_val = 4; wdt_en = 1;
    for (g = 0; g < 50 && !(m_ph[0] == 1 && m_cnt[0] == 0); g++) tick();
    if (g == 50) bound_fail("cnt_zero");
    kick = 1; tick(); kick = 0; tick();
    repeat (15) begin kick = 1; tick(); kick = 0; tick(); tick(); end

    // 64-cycle pulse with rpl_wr, kick and wdt_en=0 applied mid-pulse.
    wdt_en = 0; settle();
    rpl_wr = 1; rpl_in = 3'd5; tick(); rpl_wr = 0;
    top_val = 3; wdt_en = 1;
    for (g = 0; g < 50 && m_ph[0] != 3; g++) tick();
    if (g == 50) bound_fail("pulse_start");
    repeat (5) tick();
    rpl_wr = 1; rpl_in = 3'd0; tick(); rpl_wr = 0;
    repeat (5) tick();
    kick = 1; tick(); kick = 0;
    repeat (5) tick();
    wdt_en = 0;
    repeat (70) tick();

    // Reset asserted at pulse cycle 10.
    wdt_en = 1;
    for (g = 0; g < 100 && !(m_ph[0] == 3 && m_len[0] - m_left[0] == 10); g++) tick();
    if (g == 100) bound_fail("pulse_cycle10");
    presetn = 0; tick(); presetn = 1;
    repeat (3) tick();

    // Randomized traffic.
    repeat (3000) begin
      presetn   = ($urandom_range(0, 399) != 0);
      wdt_en    = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 49) == 0) resp_mode = ~resp_mode;
      top_val   = CW'($urandom_range(0, 6));
      kick      = ($urandom_range(0, 7) == 0);
      intr_clr  = ($urandom_range(0, 5) == 0);
      rpl_wr    = ($urandom_range(0, 19) == 0);
      rpl_in    = 3'($urandom_range(0, 7));
      tick();
    end

    presetn = 1; wdt_en = 0; kick = 0; intr_clr = 0; rpl_wr = 0;
    settle();
    repeat (3) tick();

    checks++;
    if (wq0.size() != 0 || wq1.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses got %0d/%0d unobserved want 0/0", wq0.size(), wq1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdt_rst_ctrl.md
Name: wdt_rst_ctrl

Overview:
Watchdog timer controller that sequences the system reset pulse driven onto wdt_rst.
- A down-counter reloads from a programmable top value and is restarted by software kicks.
- On timeout it either asserts wdt_rst directly or first raises an interrupt and resets only on a second timeout.
- Reset pulse length is 2^(rpl+1) pclk cycles (rpl 0..7 → 2..256 cycles). rpl is software-writable unless hard-coded by parameter.

Parameters:
- CNT_W, 16, width of the watchdog counter and top value.
- HC_RPL, 0, 1 = rpl register is read-only (writes ignored).
- DFLT_RPL, 3, reset value of rpl (3 → 16-cycle pulse).

Ports:
- pclk, in, 1, clock; all logic on rising edge.
- presetn, in, 1, reset; synchronous, active-low.
- wdt_en, in, 1, watchdog enable.
- resp_mode, in, 1, 0 = reset on first timeout; 1 = interrupt first, reset on second timeout.
- top_val, in, CNT_W, counter reload value.
- kick, in, 1, restart pulse (one cycle).
- intr_clr, in, 1, clear interrupt without reloading the counter.
- rpl_wr, in, 1, write strobe for rpl.
- rpl_in, in, 3, reset pulse length code to write.
- rpl, out, 3, current pulse length code.
- cnt, out, CNT_W, current counter value.
- wdt_intr, out, 1, timeout interrupt (level).
- wdt_rst, out, 1, system reset pulse (registered, active-high).

Behaviour:
- Reset (presetn=0 at a pclk edge):
  - state=IDLE, cnt=0, wdt_intr=0, wdt_rst=0, rpl=DFLT_RPL, pulse counter=0.
  - Reset mid-pulse drops wdt_rst on that edge.
- rpl register:
  - When rpl_wr=1, HC_RPL=0 and state≠RST, rpl←rpl_in on that edge.
  - Writes are ignored when HC_RPL=1 or during RST. Pulse length is latched at RST entry.
- States: IDLE, COUNT, INTR, RST. All outputs are registered.
- IDLE:
  - cnt holds. wdt_intr=0, wdt_rst=0.
  - wdt_en=1 → cnt←top_val, go COUNT.
- COUNT, evaluated in priority order:
  1. wdt_en=0 → IDLE (cnt holds).
  2. kick=1 → cnt←top_val.
  3. cnt==0 with resp_mode=0 → RST.
  4. cnt==0 with resp_mode=1 → wdt_intr←1, cnt←top_val, go INTR.
  5. Otherwise cnt←cnt−1.
  - Kick in the same cycle that cnt==0 wins: no timeout.
- INTR, evaluated in priority order:
  1. wdt_en=0 → IDLE, wdt_intr←0.
  2. kick=1 → cnt←top_val, wdt_intr←0, go COUNT.
  3. intr_clr=1 → wdt_intr←0, go COUNT, cnt continues decrementing.
  4. cnt==0 → RST, wdt_intr stays 1.
  5. Otherwise cnt←cnt−1.
- RST:
  - wdt_rst=1 for exactly 2^(rpl+1) consecutive cycles, using a 9-bit pulse counter.
  - On the last pulse cycle the next edge drives wdt_rst←0, wdt_intr←0, cnt←top_val, and the state goes to COUNT if wdt_en=1, else IDLE.
  - kick, intr_clr, rpl_wr and wdt_en=0 do not shorten the pulse.
- Latency:
  - Enable sampled at edge E0 → cnt=N at E1, cnt=0 at E(N+1), wdt_rst=1 from E(N+2) through E(N+1+2^(rpl+1)), 0 after.
  - top_val=0 → timeout on the first COUNT cycle.
- Back-to-back timeouts:
  - After a pulse with wdt_en still 1, counting restarts automatically from top_val.
  - No kick means periodic resets.
- top_val changes take effect only at the next reload.
- Property that must hold: $rose(wdt_rst) |-> wdt_rst[*2^(rpl+1)] ##1 $fell(wdt_rst), using rpl sampled at the rise.

Test Plan:
- DFLT_RPL=3, resp_mode=0, top_val=5, wdt_en=1 from reset release, no kicks → wdt_rst high for exactly 16 cycles starting 7 cycles after enable, then counting restarts (cnt=5).
- Sweep rpl_in=0..7 via rpl_wr (HC_RPL=0), trigger a timeout each time → pulse widths 2,4,8,16,32,64,128,256. Same sweep with HC_RPL=1 → rpl stays 3 and every pulse is 16 cycles.
- resp_mode=1, top_val=4 → wdt_intr rises after the first timeout. Then:
  - no action → wdt_rst after a further 5 cycles;
  - rerun with intr_clr in INTR → wdt_intr=0 and no reset until the next timeout pair.
- kick asserted exactly in the cnt==0 cycle → cnt reloads to top_val, no wdt_intr/wdt_rst. Kick every 3 cycles with top_val=4 → wdt_rst never asserts.
- During a 64-cycle pulse (rpl=5), the following are all ignored and the width is still 64:
  - rpl_wr with rpl_in=0 (rpl still 5 afterwards);
  - kick;
  - wdt_en=0 (state IDLE afterwards).
- presetn=0 at pulse cycle 10 → next edge wdt_rst=0, wdt_intr=0, cnt=0, rpl=DFLT_RPL, state IDLE.
